// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, 2-flop synchroniser, 3-sample majority vote at mid-bit.
// Latency: rx_valid one clk after the tick that samples the last stop bit (3-4 clks after the line sample).
// Backpressure: none on the line side; optional FIFO (macro UART_RX_FIFO_EN) drops new words when full and sets overrun.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_fpga,
    input  logic                 reset,
    input  logic                 RxD,
`ifdef UART_RX_FIFO_EN
    input  logic                 rd_en,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 overrun,
`endif
    output logic [DATA_BITS-1:0] RxData,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    // Guarded so an illegal DIV still elaborates far enough to hit the check below.
    localparam int DIV_W = (DIV < 2) ? 2 : $clog2(DIV + 1);
    localparam int SC_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  HALF_LAST = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  FULL_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (DIV < 2) begin : g_chk_div
        $error("uart_rx_param: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("uart_rx_param: OVERSAMPLE must be even and within 4..16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
        $error("uart_rx_param: DATA_BITS must be within 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  tick;
    logic                  sync1_q, rxs_q;
    logic [1:0]            vote_q;
    logic                  voted;
    logic [SC_W-1:0]       sample_cnt_q, sample_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  armed_q, armed_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_err_q, stop_err_d;
    logic                  frame_done;
    logic                  rx_valid_q;
    logic                  at_mid;

    // Free-running tick divider; only reset restarts its phase.
    always_comb div_d = tick ? '0 : div_q + DIV_W'(1);
    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk_fpga) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    // Two-flop synchroniser on the asynchronous line; idles high.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= RxD;
            rxs_q   <= sync1_q;
        end
    end

    // Keep the two previous tick samples; together with the current one they form the vote window.
    always_ff @(posedge clk_fpga) begin
        if (reset)     vote_q <= 2'b11;
        else if (tick) vote_q <= {vote_q[0], rxs_q};
    end

    assign voted  = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs_q) | (vote_q[0] & rxs_q);
    assign at_mid = (sample_cnt_q == FULL_LAST);

    // State register.
    always_ff @(posedge clk_fpga) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and counter logic; everything advances on tick only.
    // armed_q makes IDLE see a high sample before accepting a start edge, so a held-low
    // line (break) yields a single frame.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        armed_d      = armed_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (rxs_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d      = S_START;
                        sample_cnt_d = '0;
                        armed_d      = 1'b0;
                    end
                end
                S_START: begin
                    if (sample_cnt_q == HALF_LAST) begin
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        state_d      = voted ? S_IDLE : S_DATA;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SC_W'(1);
                    end
                end
                S_DATA: begin
                    if (at_mid) begin
                        sample_cnt_d = '0;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SC_W'(1);
                    end
                end
                S_PARITY: begin
                    if (at_mid) begin
                        sample_cnt_d = '0;
                        state_d      = S_STOP;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SC_W'(1);
                    end
                end
                S_STOP: begin
                    if (at_mid) begin
                        sample_cnt_d = '0;
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = S_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SC_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output/datapath logic: data shift, parity and stop checks, frame completion strobe.
    always_comb begin
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        frame_done = 1'b0;
        if (tick) begin
            case (state_q)
                S_START: begin
                    if (sample_cnt_q == HALF_LAST) begin
                        par_err_d  = 1'b0;
                        stop_err_d = 1'b0;
                    end
                end
                S_DATA: begin
                    if (at_mid) shift_d = {voted, shift_q[DATA_BITS-1:1]};
                end
                S_PARITY: begin
                    if (at_mid) par_err_d = ((^shift_q) ^ voted) != (PARITY == 1);
                end
                S_STOP: begin
                    if (at_mid) begin
                        stop_err_d = stop_err_q | ~voted;
                        frame_done = (bit_cnt_q == STOP_LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);

    // Counters and frame datapath registers; reset drops any partial word.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            armed_q      <= 1'b0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            armed_q      <= armed_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
            rx_valid_q   <= frame_done;
        end
    end

    // Every completed frame strobes rx_valid, including one the FIFO has to drop.
    assign rx_valid = rx_valid_q;

`ifdef UART_RX_FIFO_EN
    localparam int EW = DATA_BITS + 2;

    logic [EW-1:0] mem_q [4];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    cnt_q;
    logic          ovr_q;
    logic          pop, accept;

    assign pop    = rd_en && (cnt_q != 3'd0);
    assign accept = frame_done && ((cnt_q != 3'd4) || pop);

    // Four-entry first-word-fall-through FIFO of {frame_err, parity_err, data}.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= {stop_err_d, par_err_q, shift_q};
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q <= cnt_q + {2'b00, accept} - {2'b00, pop};
            if (frame_done && !accept) ovr_q <= 1'b1;
        end
    end

    assign {frame_err, parity_err, RxData} = mem_q[rd_ptr_q];
    assign fifo_empty = (cnt_q == 3'd0);
    assign fifo_full  = (cnt_q == 3'd4);
    assign overrun    = ovr_q;
`else
    logic [DATA_BITS-1:0] data_q;
    logic                 ferr_q, perr_q;

    // Delivered word and flags; flags hold until the next frame.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            data_q <= '0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else if (frame_done) begin
            data_q <= shift_q;
            ferr_q <= stop_err_d;
            perr_q <= par_err_q;
        end
    end

    assign RxData     = data_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8N1 x16, and 8E2 x8) at 32 clks per bit.
module tb_uart_rx_param;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 31_250;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       p;
    } ev_t;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       pbit;
        logic [1:0] stops;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1;
    logic [7:0] RxData0, RxData1;
    logic       rx_valid0, rx_valid1, frame_err0, frame_err1, parity_err0, parity_err1, busy0, busy1;
`ifdef UART_RX_FIFO_EN
    logic       rd_en0, rd_en1, fifo_empty0, fifo_empty1, fifo_full0, fifo_full1, overrun0, overrun1;
    logic       auto_drain, man_rd;
    assign rd_en0 = auto_drain ? !fifo_empty0 : man_rd;
    assign rd_en1 = !fifo_empty1;
`endif

    int tests = 0;
    int fails = 0;
    int vcnt0 = 0;
    ev_t q0[$];
    ev_t q1[$];
    ev_t ev0, ev1;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk_fpga(clk), .reset(rst), .RxD(rx0),
`ifdef UART_RX_FIFO_EN
        .rd_en(rd_en0), .fifo_empty(fifo_empty0), .fifo_full(fifo_full0), .overrun(overrun0),
`endif
        .RxData(RxData0), .rx_valid(rx_valid0), .frame_err(frame_err0),
        .parity_err(parity_err0), .busy(busy0)
    );

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk_fpga(clk), .reset(rst), .RxD(rx1),
`ifdef UART_RX_FIFO_EN
        .rd_en(rd_en1), .fifo_empty(fifo_empty1), .fifo_full(fifo_full1), .overrun(overrun1),
`endif
        .RxData(RxData1), .rx_valid(rx_valid1), .frame_err(frame_err1),
        .parity_err(parity_err1), .busy(busy1)
    );

    // Collect delivered words (in FIFO builds: words as they are read out).
    always @(negedge clk) begin
`ifdef UART_RX_FIFO_EN
        if (rd_en0 && !fifo_empty0) begin
`else
        if (rx_valid0) begin
`endif
            ev0.d = RxData0; ev0.f = frame_err0; ev0.p = parity_err0;
            q0.push_back(ev0);
        end
        if (rx_valid0) vcnt0++;
    end

    always @(negedge clk) begin
`ifdef UART_RX_FIFO_EN
        if (rd_en1 && !fifo_empty1) begin
`else
        if (rx_valid1) begin
`endif
            ev1.d = RxData1; ev1.f = frame_err1; ev1.p = parity_err1;
            q1.push_back(ev1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference parity rule: even mode (2) flags an odd total of ones, odd mode (1) an even total.
    function automatic logic model_perr(input logic [7:0] d, input logic pb, input int mode);
        int ones;
        ones = $countones(d) + int'(pb);
        if (mode == 0) return 1'b0;
        if (mode == 1) return (ones % 2) == 0;
        return (ones % 2) == 1;
    endfunction

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx0 = v; else rx1 = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // dut0 frames: start, 8 data, 1 stop. dut1 frames: start, 8 data, parity, 2 stops.
    // A low final stop is followed by one idle bit so the receiver can re-arm.
    task automatic send_frame(input int which, input logic [7:0] d, input logic pb, input logic [1:0] st);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (which == 1) drive_bit(which, pb);
        drive_bit(which, st[0]);
        if (which == 1) drive_bit(which, st[1]);
        if ((which == 0 && !st[0]) || (which == 1 && !st[1])) drive_bit(which, 1'b1);
    endtask

    task automatic take(input int which, output int n, output ev_t e);
        e = '{8'h00, 1'b0, 1'b0};
        if (which == 0) begin
            n = q0.size();
            if (n > 0) e = q0.pop_front();
            q0.delete();
        end else begin
            n = q1.size();
            if (n > 0) e = q1.pop_front();
            q1.delete();
        end
    endtask

    task automatic check_frame(input int which, input string name, input logic [7:0] d,
                               input logic f, input logic p);
        int  n;
        ev_t e;
        take(which, n, e);
        check({name, " count"}, n, 1);
        check({name, " data"}, int'(e.d), int'(d));
        check({name, " frame_err"}, int'(e.f), int'(f));
        check({name, " parity_err"}, int'(e.p), int'(p));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    vec_t       vec[10];
    logic [7:0] rd;
    logic       rpb;
    logic [1:0] rst_bits;
    logic       busy_seen;
    int         which, vstart;

    initial begin
        vec[0] = '{0, 8'h55, 1'b0, 2'b11, 8'h55, 1'b0, 1'b0};
        vec[1] = '{0, 8'hA3, 1'b0, 2'b11, 8'hA3, 1'b0, 1'b0};
        vec[2] = '{0, 8'h3C, 1'b0, 2'b10, 8'h3C, 1'b1, 1'b0};
        vec[3] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
        vec[4] = '{1, 8'h0F, 1'b1, 2'b11, 8'h0F, 1'b0, 1'b1};
        vec[5] = '{1, 8'h0F, 1'b0, 2'b11, 8'h0F, 1'b0, 1'b0};
        vec[6] = '{1, 8'h80, 1'b1, 2'b11, 8'h80, 1'b0, 1'b0};
        vec[7] = '{1, 8'hC3, 1'b0, 2'b01, 8'hC3, 1'b1, 1'b0};
        vec[8] = '{1, 8'hFF, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b1};
        vec[9] = '{1, 8'h7E, 1'b0, 2'b10, 8'h7E, 1'b1, 1'b0};

`ifdef UART_RX_FIFO_EN
        auto_drain = 1'b1;
        man_rd     = 1'b0;
`endif
        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset RxData0", int'(RxData0), 0);
        check("reset rx_valid0", int'(rx_valid0), 0);
        check("reset frame_err0", int'(frame_err0), 0);
        check("reset parity_err0", int'(parity_err0), 0);
        check("reset busy0", int'(busy0), 0);
        check("reset busy1", int'(busy1), 0);
        check("reset RxData1", int'(RxData1), 0);
        repeat (BIT_CLKS) @(negedge clk);

        // Table: frames on each line go back-to-back (no idle beyond the stop bits).
        for (int i = 0; i < 10; i++) begin
            send_frame(vec[i].dut, vec[i].data, vec[i].pbit, vec[i].stops);
            check_frame(vec[i].dut, $sformatf("vec%0d", i), vec[i].exp_data,
                        vec[i].exp_ferr, vec[i].exp_perr);
        end

        // Glitch a little under half a bit on an idle line: start is rejected at the mid-bit vote.
        repeat (2 * BIT_CLKS) @(negedge clk);
        q0.delete();
        busy_seen = 1'b0;
        rx0 = 1'b0;
        for (int c = 0; c < BIT_CLKS; c++) begin
            if (c == 12) rx0 = 1'b1;
            @(negedge clk);
            if (busy0) busy_seen = 1'b1;
        end
        check("glitch busy seen", int'(busy_seen), 1);
        check("glitch busy cleared in 1 bit", int'(busy0), 0);
        repeat (12 * BIT_CLKS) @(negedge clk);
        check("glitch no frame", q0.size(), 0);

        // Break: line low for 20 bit times gives exactly one zero frame with frame_err.
        rx0 = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check_frame(0, "break", 8'h00, 1'b1, 1'b0);
        rx0 = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("break no refire", q0.size(), 0);
        send_frame(0, 8'h5A, 1'b0, 2'b11);
        check_frame(0, "after break", 8'h5A, 1'b0, 1'b0);

        // Reset in the middle of data bit 4 of 0x81.
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        rx0 = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("pre-reset busy0", int'(busy0), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset RxData0", int'(RxData0), 0);
        check("midreset rx_valid0", int'(rx_valid0), 0);
        check("midreset busy0", int'(busy0), 0);
        check("midreset frame_err0", int'(frame_err0), 0);
        rst = 1'b0;
        rx0 = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("midreset no frame", q0.size(), 0);
        send_frame(0, 8'h81, 1'b0, 2'b11);
        check_frame(0, "after reset", 8'h81, 1'b0, 1'b0);

        // Randomised frames against the reference rules.
        for (int r = 0; r < 24; r++) begin
            which = r % 2;
            rd    = 8'($urandom);
            rpb   = 1'($urandom);
            rst_bits[0] = ($urandom_range(0, 4) != 0);
            rst_bits[1] = (which == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) drive_bit(which, 1'b1);
            send_frame(which, rd, rpb, rst_bits);
            check_frame(which, $sformatf("rand%0d", r), rd,
                        (which == 0) ? !rst_bits[0] : !(rst_bits[0] & rst_bits[1]),
                        model_perr(rd, rpb, (which == 0) ? 0 : 2));
        end

`ifdef UART_RX_FIFO_EN
        // Five frames with no reads: four stored, fifth dropped with overrun.
        auto_drain = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        q0.delete();
        vstart = vcnt0;
        for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 2'b11);
        @(negedge clk);
        check("fifo rx_valid pulses", vcnt0 - vstart, 5);
        check("fifo_full", int'(fifo_full0), 1);
        check("overrun", int'(overrun0), 1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("fifo read %0d", k), int'(RxData0), k);
            man_rd = 1'b1;
            @(negedge clk);
            man_rd = 1'b0;
        end
        check("fifo_empty", int'(fifo_empty0), 1);
        auto_drain = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
